game_move_controller: RTL and testbench
=======================================

GAME_MOVE_CONTROLLER -- requirements
Module: game_move_controller

Interface
REQ-001 Parameter TILE_W, default 12, tile value width in bits.
REQ-002 Parameter WIN_VALUE, default 2048, tile value that ends the game as won.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 new_game  input  1  single-cycle request to clear the board and start a game.
REQ-006 move_valid  input  1  move request strobe.
REQ-007 move_dir  input  2  direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 move_ready  output  1  controller accepts a move this cycle.
REQ-009 om  input  TILE_W x [3:0][3:0]  selected candidate board returned by the 4-matrix mux.
REQ-010 sel  output  2  mux select, equal to the latched move_dir.
REQ-011 rnd_idx  input  4  random start cell index (row*4+col) for tile spawn.
REQ-012 rnd_four  input  1  spawn value 4 when 1, else 2.
REQ-013 board  output  TILE_W x [3:0][3:0]  registered current board.
REQ-014 move_done  output  1  one-cycle pulse when a move completes.
REQ-015 moved  output  1  qualifies move_done: 1 if the board changed.
REQ-016 win  output  1  sticky, a tile equals WIN_VALUE.
REQ-017 lose  output  1  sticky, no empty cell and no equal orthogonal neighbours.

Function
REQ-018 FSM states: IDLE, SELECT, COMMIT, SPAWN, CHECK, OVER.
REQ-019 move_ready = 1 only in IDLE; a move is accepted when move_valid && move_ready.
REQ-020 On accept: sel <= move_dir, next state SELECT; sel holds until the next accept.
REQ-021 SELECT lasts exactly 1 cycle, giving the mux one settle cycle; no other action.
REQ-022 COMMIT: if om != board, board <= om, moved <= 1, next state SPAWN; else moved <= 0, move_done pulses, next state IDLE.
REQ-023 SPAWN: write 2 or 4 (rnd_four) into the first zero cell searching upward from rnd_idx, wrapping 15 -> 0; at most one write; no write if no zero cell; next state CHECK.
REQ-024 CHECK: evaluate on the post-spawn board; set win if any cell == WIN_VALUE; set lose if no cell is zero and no horizontally or vertically adjacent pair is equal.
REQ-025 CHECK exit: if win or lose, go to OVER, else go to IDLE; move_done pulses in the CHECK cycle whenever the move reached CHECK.
REQ-026 Latency from accept to move_done: 4 cycles for a changed board, 2 cycles for an unchanged board.
REQ-027 OVER: move_ready = 0 and move_valid is ignored; board, win and lose hold.
REQ-028 new_game in IDLE or OVER: board <= all zero, win/lose <= 0, next state SPAWN (one tile placed at rnd_idx); new_game in any other state is ignored.
REQ-029 new_game and move_valid in the same IDLE cycle: new_game wins, the move is dropped.
REQ-030 Zero denotes an empty cell; tile values are never incremented here, so no overflow handling is required.

Reset
REQ-031 On rst_n = 0 at a clock edge: state IDLE, board all zero, sel 00, move_done 0, moved 0, win 0, lose 0.
REQ-032 Reset mid-move aborts the move with no partial board update visible after the reset edge.
REQ-033 After reset, the board stays empty until new_game arrives.

Structure
REQ-034 Shared package game_pkg holds: TILE_W, WIN_VALUE, direction encodings, board typedef (TILE_W x 4 x 4), and the FSM state enum.
REQ-035 The rotated first-empty search and value write are a sub-module, tile_spawner: inputs board, rnd_idx and rnd_four; outputs next board and a found flag; purely combinational.

Verification
REQ-036 Reset, then new_game with rnd_idx=5, rnd_four=0 -> after CHECK, board[1][1]=2, all other cells 0, move_ready=1.
REQ-037 om differs from board, move_dir=10 -> sel=10 one cycle after accept; move_done && moved 4 cycles after accept; board = om plus exactly one new tile.
REQ-038 om equals board -> move_done=1 and moved=0 2 cycles after accept; board unchanged; no spawn.
REQ-039 Only cell 0 empty, rnd_idx=15 -> search wraps and the spawn lands in cell 0.
REQ-040 om contains a tile of 2048 -> win=1, state OVER, move_ready=0; a subsequent move_valid has no effect; new_game clears win.
REQ-041 Full board with no equal neighbours after spawn -> lose=1; rst_n low mid-SPAWN -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared widths, direction codes, board type and FSM states for the 2048 move controller
package game_pkg;
   localparam int TILE_W    = 12;
   localparam int WIN_VALUE = 2048;
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;
   typedef logic [3:0][3:0][TILE_W-1:0] board_t;
   typedef enum logic [2:0] {IDLE, SELECT, COMMIT, SPAWN, CHECK, OVER} state_t;
endpackage

// File: rtl/tile_spawner.sv
// tile_spawner: places a 2 or 4 in the first empty cell found scanning upward from rnd_idx with wrap
module tile_spawner #(
   parameter int TILE_W = 12
) (
   input  logic [3:0][3:0][TILE_W-1:0] board_i,
   input  logic [3:0]                  rnd_idx_i,
   input  logic                        rnd_four_i,
   output logic [3:0][3:0][TILE_W-1:0] board_o,
   output logic                        found_o
);
   import game_pkg::*;
   logic [3:0] idx;
   // rotated first-empty search; found_o blocks any write after the first hit
   always_comb begin
      board_o = board_i;
      found_o = 1'b0;
      idx     = '0;
      for (int k = 0; k < 16; k++) begin
         idx = rnd_idx_i + 4'(k);
         if (!found_o && board_i[idx[3:2]][idx[1:0]] == '0) begin
            board_o[idx[3:2]][idx[1:0]] = rnd_four_i ? TILE_W'(4) : TILE_W'(2);
            found_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/game_move_controller.sv
// game_move_controller: sequences a move through mux select, commit, tile spawn and win/lose check
module game_move_controller #(
   parameter int TILE_W    = game_pkg::TILE_W,
   parameter int WIN_VALUE = game_pkg::WIN_VALUE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        new_game,
   input  logic                        move_valid,
   input  logic [1:0]                  move_dir,
   output logic                        move_ready,
   input  logic [3:0][3:0][TILE_W-1:0] om,
   output logic [1:0]                  sel,
   input  logic [3:0]                  rnd_idx,
   input  logic                        rnd_four,
   output logic [3:0][3:0][TILE_W-1:0] board,
   output logic                        move_done,
   output logic                        moved,
   output logic                        win,
   output logic                        lose
);
   import game_pkg::*;
   state_t state_q, state_d;
   logic [3:0][3:0][TILE_W-1:0] board_q, board_d, spawn_board;
   logic [1:0] sel_q, sel_d;
   logic moved_q, moved_d, win_q, win_d, lose_q, lose_d;
   logic spawn_found, has_win, has_zero, has_pair;

   tile_spawner #(.TILE_W(TILE_W)) u_spawner (
      .board_i   (board_q),
      .rnd_idx_i (rnd_idx),
      .rnd_four_i(rnd_four),
      .board_o   (spawn_board),
      .found_o   (spawn_found)
   );

   assign move_ready = state_q == IDLE;
   assign sel        = sel_q;
   assign board      = board_q;
   assign moved      = moved_q;
   assign win        = win_q;
   assign lose       = lose_q;

   // board scan for a winning tile, an empty cell and any equal orthogonal neighbours
   always_comb begin
      has_win  = 1'b0;
      has_zero = 1'b0;
      has_pair = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (board_q[r][c] == TILE_W'(WIN_VALUE)) has_win = 1'b1;
            if (board_q[r][c] == '0) has_zero = 1'b1;
         end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            if (board_q[r][c] == board_q[r+1][c]) has_pair = 1'b1;
   end

   // next-state and outputs; moved_q is cleared on accept so an unchanged move reports moved=0 in COMMIT
   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      sel_d     = sel_q;
      moved_d   = moved_q;
      win_d     = win_q;
      lose_d    = lose_q;
      move_done = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (new_game) begin
               board_d = '0;
               win_d   = 1'b0;
               lose_d  = 1'b0;
               moved_d = 1'b0;
               state_d = SPAWN;
            end else if (state_q == IDLE && move_valid) begin
               sel_d   = move_dir;
               moved_d = 1'b0;
               state_d = SELECT;
            end
         end
         SELECT: state_d = COMMIT;
         COMMIT: begin
            if (om != board_q) begin
               board_d = om;
               moved_d = 1'b1;
               state_d = SPAWN;
            end else begin
               move_done = 1'b1;
               state_d   = IDLE;
            end
         end
         SPAWN: begin
            board_d = spawn_found ? spawn_board : board_q;
            state_d = CHECK;
         end
         CHECK: begin
            move_done = moved_q;
            win_d     = win_q | has_win;
            lose_d    = lose_q | (!has_zero && !has_pair);
            state_d   = (win_d || lose_d) ? OVER : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         board_q <= '0;
         sel_q   <= '0;
         moved_q <= 1'b0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         sel_q   <= sel_d;
         moved_q <= moved_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
      end
   end
endmodule

// File: tb/tb_game_move_controller.sv
// tb_game_move_controller: directed scenario tests for the move controller
module tb_game_move_controller;
   import game_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, new_game = 1'b0, move_valid = 1'b0, rnd_four = 1'b0;
   logic [1:0] move_dir = 2'b00;
   logic [3:0] rnd_idx = 4'd0;
   board_t om = '0;
   board_t board, exp_b;
   logic move_ready, move_done, moved, win, lose;
   logic [1:0] sel;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   game_move_controller dut (
      .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
      .move_dir(move_dir), .move_ready(move_ready), .om(om), .sel(sel),
      .rnd_idx(rnd_idx), .rnd_four(rnd_four), .board(board), .move_done(move_done),
      .moved(moved), .win(win), .lose(lose)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      total++; if (board !== '0) $display("FAIL rst_board: got %h want 0", board); else passed++;
      total++; if (move_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", move_ready); else passed++;
      total++; if (sel !== 2'b00) $display("FAIL rst_sel: got %b want 00", sel); else passed++;
      total++; if ({move_done, moved, win, lose} !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", {move_done, moved, win, lose}); else passed++;
      cyc(3);
      total++; if (board !== '0) $display("FAIL rst_stays_empty: got %h want 0", board); else passed++;
   endtask

   task automatic test_new_game;
      new_game = 1'b1; rnd_idx = 4'd5; rnd_four = 1'b0;
      cyc(1);
      new_game = 1'b0;
      total++; if (move_ready !== 1'b0) $display("FAIL ng_busy_ready: got %b want 0", move_ready); else passed++;
      cyc(2);
      exp_b = '0; exp_b[1][1] = 12'd2;
      total++; if (board !== exp_b) $display("FAIL ng_board: got %h want %h", board, exp_b); else passed++;
      total++; if (move_ready !== 1'b1) $display("FAIL ng_ready: got %b want 1", move_ready); else passed++;
   endtask

   task automatic test_move_changed;
      board_t o;
      o = '0; o[1][0] = 12'd2;
      om = o; move_dir = 2'b10; rnd_idx = 4'd0; rnd_four = 1'b1; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      total++; if (sel !== 2'b10) $display("FAIL chg_sel: got %b want 10", sel); else passed++;
      total++; if (move_ready !== 1'b0) $display("FAIL chg_ready_busy: got %b want 0", move_ready); else passed++;
      cyc(1);
      total++; if (move_done !== 1'b0) $display("FAIL chg_commit_done: got %b want 0", move_done); else passed++;
      cyc(1);
      total++; if (board !== o) $display("FAIL chg_commit_board: got %h want %h", board, o); else passed++;
      cyc(1);
      exp_b = o; exp_b[0][0] = 12'd4;
      total++; if ({move_done, moved} !== 2'b11) $display("FAIL chg_done_moved: got %b want 11", {move_done, moved}); else passed++;
      total++; if (board !== exp_b) $display("FAIL chg_board: got %h want %h", board, exp_b); else passed++;
      cyc(1);
      total++; if ({move_ready, move_done} !== 2'b10) $display("FAIL chg_idle: got %b want 10", {move_ready, move_done}); else passed++;
   endtask

   task automatic test_move_unchanged;
      om = exp_b; move_dir = 2'b01; rnd_idx = 4'd3; rnd_four = 1'b0; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      total++; if (sel !== 2'b01) $display("FAIL same_sel: got %b want 01", sel); else passed++;
      cyc(1);
      total++; if ({move_done, moved} !== 2'b10) $display("FAIL same_done_moved: got %b want 10", {move_done, moved}); else passed++;
      cyc(1);
      total++; if (board !== exp_b) $display("FAIL same_board: got %h want %h", board, exp_b); else passed++;
      total++; if ({move_ready, move_done} !== 2'b10) $display("FAIL same_idle: got %b want 10", {move_ready, move_done}); else passed++;
   endtask

   task automatic test_wrap_spawn;
      board_t o;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[r][c] = 12'd2;
      exp_b = o;
      o[0][0] = 12'd0;
      om = o; move_dir = 2'b00; rnd_idx = 4'd15; rnd_four = 1'b0; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      cyc(3);
      total++; if (move_done !== 1'b1) $display("FAIL wrap_done: got %b want 1", move_done); else passed++;
      total++; if (board !== exp_b) $display("FAIL wrap_board: got %h want %h", board, exp_b); else passed++;
      cyc(1);
      total++; if ({move_ready, win, lose} !== 3'b100) $display("FAIL wrap_state: got %b want 100", {move_ready, win, lose}); else passed++;
   endtask

   task automatic test_win_over;
      board_t o;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[r][c] = 12'd2;
      o[3][3] = 12'd2048;
      om = o; move_dir = 2'b11; rnd_idx = 4'd2; rnd_four = 1'b1; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      total++; if (sel !== 2'b11) $display("FAIL win_sel: got %b want 11", sel); else passed++;
      cyc(3);
      total++; if (move_done !== 1'b1) $display("FAIL win_done: got %b want 1", move_done); else passed++;
      total++; if (board !== o) $display("FAIL win_board_nospawn: got %h want %h", board, o); else passed++;
      cyc(1);
      total++; if ({win, lose, move_ready} !== 3'b100) $display("FAIL win_over: got %b want 100", {win, lose, move_ready}); else passed++;
      om = '0; move_dir = 2'b00; move_valid = 1'b1;
      cyc(4);
      total++; if (move_done !== 1'b0) $display("FAIL over_no_done: got %b want 0", move_done); else passed++;
      move_valid = 1'b0;
      total++; if (board !== o) $display("FAIL over_board_hold: got %h want %h", board, o); else passed++;
      total++; if ({sel, win, move_ready} !== 4'b1110) $display("FAIL over_hold: got %b want 1110", {sel, win, move_ready}); else passed++;
      new_game = 1'b1; rnd_idx = 4'd7; rnd_four = 1'b1;
      cyc(1);
      new_game = 1'b0;
      total++; if (win !== 1'b0) $display("FAIL win_cleared: got %b want 0", win); else passed++;
      cyc(2);
      exp_b = '0; exp_b[1][3] = 12'd4;
      total++; if (board !== exp_b) $display("FAIL restart_board: got %h want %h", board, exp_b); else passed++;
      total++; if (move_ready !== 1'b1) $display("FAIL restart_ready: got %b want 1", move_ready); else passed++;
   endtask

   task automatic test_new_game_priority;
      om = '1; move_dir = 2'b01; move_valid = 1'b1; new_game = 1'b1; rnd_idx = 4'd0; rnd_four = 1'b0;
      cyc(1);
      move_valid = 1'b0; new_game = 1'b0;
      total++; if (sel !== 2'b11) $display("FAIL prio_sel: got %b want 11", sel); else passed++;
      cyc(2);
      exp_b = '0; exp_b[0][0] = 12'd2;
      total++; if (board !== exp_b) $display("FAIL prio_board: got %h want %h", board, exp_b); else passed++;
   endtask

   task automatic test_reset_mid_spawn;
      board_t o;
      o = '0; o[0][3] = 12'd2;
      om = o; move_dir = 2'b10; rnd_idx = 4'd0; rnd_four = 1'b0; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      cyc(2);
      total++; if ({board === o, moved} !== 2'b11) $display("FAIL mid_in_spawn: got %b want 11", {board === o, moved}); else passed++;
      rst_n = 1'b0;
      cyc(1);
      total++; if (board !== '0) $display("FAIL mid_rst_board: got %h want 0", board); else passed++;
      total++; if ({sel, move_ready, move_done, moved, win, lose} !== 7'b0010000) $display("FAIL mid_rst_outs: got %b want 0010000", {sel, move_ready, move_done, moved, win, lose}); else passed++;
      rst_n = 1'b1;
      cyc(3);
      total++; if (board !== '0) $display("FAIL mid_rst_empty: got %h want 0", board); else passed++;
   endtask

   task automatic test_lose;
      board_t o;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
      exp_b = o;
      o[2][1] = 12'd0;
      om = o; move_dir = 2'b00; rnd_idx = 4'd9; rnd_four = 1'b1; move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      cyc(3);
      total++; if ({move_done, moved} !== 2'b11) $display("FAIL lose_done: got %b want 11", {move_done, moved}); else passed++;
      total++; if (board !== exp_b) $display("FAIL lose_board: got %h want %h", board, exp_b); else passed++;
      cyc(1);
      total++; if ({lose, win, move_ready} !== 3'b100) $display("FAIL lose_over: got %b want 100", {lose, win, move_ready}); else passed++;
   endtask

   initial begin
      test_reset();
      test_new_game();
      test_move_changed();
      test_move_unchanged();
      test_wrap_spawn();
      test_win_over();
      test_new_game_priority();
      test_reset_mid_spawn();
      test_lose();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
